// File: rtl/shift_arbiter.sv
// -----------------------------------------------------------------------------
// shift_arbiter
//   Shares one external 32-bit barrel shifter (1-cycle registered latency)
//   among N_REQ requesters. Requests use valid/ready handshakes, and results
//   leave in grant order through a 2-entry response buffer tagged with the
//   requester index.
//
// Configuration macro:
//   SHIFT_ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins
//                            undefined -> round-robin arbitration (default)
//
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_req_valid / o_req_ready    per-requester handshake (ready is a one-hot grant)
//   i_req_signed/left/amt/data   per-requester operation fields (packed)
//   o_sh_*                       operands to the shifter
//   i_sh_data                    shifter result, valid one cycle after operands
//   o_rsp_valid/id/data          head of the response buffer
//   i_rsp_ready                  response accept
// -----------------------------------------------------------------------------
module shift_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [N_REQ-1:0]      i_req_valid,
    output logic [N_REQ-1:0]      o_req_ready,
    input  logic [N_REQ-1:0]      i_req_signed,
    input  logic [N_REQ-1:0]      i_req_left,
    input  logic [5*N_REQ-1:0]    i_req_amt,
    input  logic [32*N_REQ-1:0]   i_req_data,
    output logic                  o_sh_signed,
    output logic                  o_sh_shift_left,
    output logic [4:0]            o_sh_shift_amt,
    output logic [31:0]           o_sh_data,
    input  logic [31:0]           i_sh_data,
    output logic                  o_rsp_valid,
    output logic [ID_W-1:0]       o_rsp_id,
    output logic [31:0]           o_rsp_data,
    input  logic                  i_rsp_ready
);

    logic                 inflight_r;
    logic [ID_W-1:0]      inflight_id_r;
    logic [31:0]          buf_data_r [2];
    logic [ID_W-1:0]      buf_id_r   [2];
    logic                 wr_ptr_r;
    logic                 rd_ptr_r;
    logic [1:0]           count_r;

    logic                 sh_signed_r;
    logic                 sh_left_r;
    logic [4:0]           sh_amt_r;
    logic [31:0]          sh_data_r;

    logic                 push_s;
    logic                 pop_s;
    logic [2:0]           occ_s;
    logic                 issue_ok_s;
    logic                 grant_vld_s;
    logic [ID_W-1:0]      grant_idx_s;
    int                   cand_s;
    logic [ID_W-1:0]      cand_idx_s;

`ifndef SHIFT_ARB_FIXED_PRIO_EN
    logic [ID_W-1:0]      rr_ptr_r;
`endif

    assign push_s = inflight_r;
    assign pop_s  = (count_r != 2'd0) && i_rsp_ready;

    // Slot accounting: a buffered entry plus the in-flight op each hold a slot;
    // a pop in the same cycle frees one, which keeps throughput at 1 op/cycle.
    always_comb begin
        occ_s      = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
        issue_ok_s = (occ_s < 3'd2) && !i_rst;
    end

    // Arbitration scan: first valid requester starting from the priority origin.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_idx_s = '0;
        cand_s      = 0;
        cand_idx_s  = '0;
        for (int i = 0; i < N_REQ; i++) begin
`ifdef SHIFT_ARB_FIXED_PRIO_EN
            cand_s = i;
`else
            cand_s = int'(rr_ptr_r) + i;
            if (cand_s >= N_REQ) begin
                cand_s = cand_s - N_REQ;
            end else begin
                cand_s = cand_s;
            end
`endif
            cand_idx_s = cand_s[ID_W-1:0];
            if (issue_ok_s && !grant_vld_s && i_req_valid[cand_idx_s]) begin
                grant_vld_s = 1'b1;
                grant_idx_s = cand_idx_s;
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
    end

    // Grant vector and shifter operands; operands hold their last value when idle.
    always_comb begin
        o_req_ready     = '0;
        o_sh_signed     = sh_signed_r;
        o_sh_shift_left = sh_left_r;
        o_sh_shift_amt  = sh_amt_r;
        o_sh_data       = sh_data_r;
        if (grant_vld_s) begin
            o_req_ready[grant_idx_s] = 1'b1;
            o_sh_signed     = i_req_signed[grant_idx_s];
            o_sh_shift_left = i_req_left[grant_idx_s];
            o_sh_shift_amt  = i_req_amt[5*int'(grant_idx_s) +: 5];
            o_sh_data       = i_req_data[32*int'(grant_idx_s) +: 32];
        end else begin
            o_req_ready     = '0;
        end
    end

    // In-flight tracking and operand hold registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            inflight_r    <= 1'b0;
            inflight_id_r <= '0;
            sh_signed_r   <= 1'b0;
            sh_left_r     <= 1'b0;
            sh_amt_r      <= 5'd0;
            sh_data_r     <= 32'd0;
        end else begin
            inflight_r <= grant_vld_s;
            if (grant_vld_s) begin
                inflight_id_r <= grant_idx_s;
                sh_signed_r   <= o_sh_signed;
                sh_left_r     <= o_sh_shift_left;
                sh_amt_r      <= o_sh_shift_amt;
                sh_data_r     <= o_sh_data;
            end
        end
    end

`ifndef SHIFT_ARB_FIXED_PRIO_EN
    // Round-robin pointer: moves past the granted requester, held otherwise.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rr_ptr_r <= '0;
        end else if (grant_vld_s) begin
            if (grant_idx_s == ID_W'(N_REQ - 1)) begin
                rr_ptr_r <= '0;
            end else begin
                rr_ptr_r <= grant_idx_s + ID_W'(1);
            end
        end
    end
`endif

    // Response FIFO: captures the shifter result the cycle after each grant.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int e = 0; e < 2; e++) begin
                buf_data_r[e] <= 32'd0;
                buf_id_r[e]   <= '0;
            end
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_s) begin
                buf_data_r[wr_ptr_r] <= i_sh_data;
                buf_id_r[wr_ptr_r]   <= inflight_id_r;
                wr_ptr_r             <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            count_r <= count_r + {1'b0, push_s} - {1'b0, pop_s};
        end
    end

    assign o_rsp_valid = (count_r != 2'd0);
    assign o_rsp_id    = buf_id_r[rd_ptr_r];
    assign o_rsp_data  = buf_data_r[rd_ptr_r];

endmodule
